booth_seq_multiplier: RTL

BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

---
 rtl/booth_seq_multiplier_if.sv | 24 ++
 rtl/booth_seq_multiplier.sv | 74 +++++++
 2 files changed

// File: rtl/booth_seq_multiplier_if.sv
// booth_seq_multiplier_if: operand/product handshake bundle for booth_seq_multiplier
// in_valid/in_ready   : operand pair handshake (multiplicand, multiplier)
// out_valid/out_ready : product handshake
// busy                : multiplier is running or holding a result
interface booth_seq_multiplier_if #(
    parameter int DATA_WIDTH = 6
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     multiplicand;
    logic [DATA_WIDTH-1:0]     multiplier;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*DATA_WIDTH-1:0]   product;
    logic                      busy;
    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product, busy
    );
    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential radix-4 Booth signed multiplier, one digit per cycle
// clk, rst (async, active-high)
// bus.slave: in_valid/in_ready + multiplicand/multiplier in, out_valid/out_ready + product out, busy
// Optional BOOTH_EARLY_TERM_EN: finish as soon as the remaining Booth digits are all zero.
module booth_seq_multiplier #(
    parameter int DATA_WIDTH = 6
) (
    input logic clk,
    input logic rst,
    booth_seq_multiplier_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int N  = (W + 1) / 2;
    localparam int BW = 2 * N;
    localparam int PW = 2 * W;
    localparam int IW = $clog2(N + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]           state;
    logic [PW-1:0]        acc;
    logic [PW-1:0]        a_sh;
    logic [PW-1:0]        mag;
    logic [PW-1:0]        addend;
    logic [BW:0]          bsh;
    logic signed [BW-1:0] b_ext;
    logic [IW-1:0]        idx;
    logic [2:0]           d;
    logic                 zero;
    logic                 two;
    logic                 last;
    logic                 fin;
    assign b_ext = signed'(bus.multiplier);
    // bsh[2:0] is always the current digit window {B[2i+1],B[2i],B[2i-1]}
    assign d      = bsh[2:0];
    assign zero   = (d == 3'b000) || (d == 3'b111);
    assign two    = (d == 3'b011) || (d == 3'b100);
    assign mag    = zero ? '0 : two ? a_sh << 1 : a_sh;
    assign addend = d[2] ? -mag : mag;
    assign last   = idx == IW'(N - 1);
`ifdef BOOTH_EARLY_TERM_EN
    // bsh[BW:2] holds the next look-back bit and every unretired B bit; all equal => only zero digits remain
    assign fin = last || (&bsh[BW:2]) || ~|bsh[BW:2];
`else
    assign fin = last;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            a_sh  <= '0;
            bsh   <= '0;
            idx   <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            state <= RUN;
            acc   <= '0;
            a_sh  <= {{W{bus.multiplicand[W-1]}}, bus.multiplicand};
            bsh   <= {b_ext, 1'b0};
            idx   <= '0;
        end else if (state == RUN) begin
            acc   <= acc + addend;
            a_sh  <= a_sh << 2;
            bsh   <= {{2{bsh[BW]}}, bsh[BW:2]};
            idx   <= idx + IW'(1);
            state <= fin ? DONE : RUN;
        end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
        end
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.product   = acc;
endmodule
